cdc_word_handshake: RTL and testbench

Moves a pWIDTH-bit data word from the clkin domain to the clkout domain using a four-phase req/ack handshake, and returns a completion pulse to the clkin side. It complements the single-bit pulse synchronizer. That block carries only event pulses from clkin to clkout. This block carries a full data word with it, and also brings acknowledgement back into clkin so the producer knows when the word has landed. The data word never passes through a synchronizer: it is sampled in the clkout domain only while req holds it stable.

---
 rtl/cdc_word_handshake.sv | 143 ++++++++++++++
 tb/tb_cdc_word_handshake.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_word_handshake.sv
// Four-phase req/ack word transfer from clkin to clkout with a completion pulse back to clkin.
// The word itself is never synchronized; clkout samples hold only while req keeps it stable.
module cdc_word_handshake #(
    parameter int pWIDTH = 16,
    parameter int pSYNC  = 2,
    parameter int pCNT   = 8
) (
    input  logic              clkin,
    input  logic              resetin,
    input  logic              clkout,
    input  logic              resetout,
    input  logic              sin_valid,
    input  logic [pWIDTH-1:0] sin_data,
    output logic              sin_ready,
    output logic              sin_done,
    output logic [pCNT-1:0]   drop_cnt,
    output logic              sout_valid,
    output logic [pWIDTH-1:0] sout_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    // clkin domain
    state_t              state_reg, state_next;
    logic                req_reg, req_next;
    logic                sin_done_reg, sin_done_next;
    logic [pWIDTH-1:0]   hold_reg;
    logic [pCNT-1:0]     drop_cnt_reg;
    logic [pSYNC-1:0]    ack_sync_reg;
    logic                ack_s;
    logic                ready_dec;
    logic                accept;
    logic                drop;

    // clkout domain
    logic [pSYNC-1:0]    req_sync_reg;
    logic                req_s;
    logic                req_d_reg;
    logic                req_rise;
    logic                ack_reg;
    logic                sout_valid_reg;
    logic [pWIDTH-1:0]   sout_data_reg;

    assign ack_s  = ack_sync_reg[pSYNC-1];
    assign accept = sin_valid & ready_dec;
    assign drop   = sin_valid & ~ready_dec;

    always_ff @(posedge clkin or posedge resetin) begin
        if (resetin) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        sin_done_next = 1'b0;
        ready_dec     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A stale ack from an aborted transfer must drain before a new word is taken
                ready_dec = ~ack_s;
                if (sin_valid && !ack_s) begin
                    req_next   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    sin_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkin or posedge resetin) begin
        if (resetin) begin
            req_reg      <= 1'b0;
            sin_done_reg <= 1'b0;
            hold_reg     <= '0;
            drop_cnt_reg <= '0;
            ack_sync_reg <= '0;
        end else begin
            req_reg      <= req_next;
            sin_done_reg <= sin_done_next;
            ack_sync_reg <= {ack_sync_reg[pSYNC-2:0], ack_reg};
            if (accept) begin
                hold_reg <= sin_data;
            end
            if (drop && (drop_cnt_reg != {pCNT{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + pCNT'(1);
            end
        end
    end

    assign req_s    = req_sync_reg[pSYNC-1];
    assign req_rise = req_s & ~req_d_reg;

    always_ff @(posedge clkout or posedge resetout) begin
        if (resetout) begin
            req_sync_reg   <= '0;
            req_d_reg      <= 1'b0;
            ack_reg        <= 1'b0;
            sout_valid_reg <= 1'b0;
            sout_data_reg  <= '0;
        end else begin
            req_sync_reg   <= {req_sync_reg[pSYNC-2:0], req_reg};
            req_d_reg      <= req_s;
            sout_valid_reg <= req_rise;
            // hold is quiet here: it only changes while req is low on the source side
            if (req_rise) begin
                sout_data_reg <= hold_reg;
                ack_reg       <= 1'b1;
            end else if (!req_s) begin
                ack_reg <= 1'b0;
            end
        end
    end

    assign sin_ready  = ready_dec;
    assign sin_done   = sin_done_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign sout_valid = sout_valid_reg;
    assign sout_data  = sout_data_reg;

endmodule

// File: tb/tb_cdc_word_handshake.sv
// Directed and randomized checks of cdc_word_handshake across several clock ratios.
`timescale 1ns/10ps
module tb_cdc_word_handshake;

    localparam int W = 16;

    logic          clkin = 1'b0;
    logic          clkout = 1'b0;
    logic          resetin;
    logic          resetout;
    logic          sin_valid;
    logic [W-1:0]  sin_data;
    logic          sin_ready, sin_done, sout_valid;
    logic [7:0]    drop_cnt;
    logic [W-1:0]  sout_data;
    logic          sin_ready4, sin_done4, sout_valid4;
    logic [3:0]    drop_cnt4;
    logic [W-1:0]  sout_data4;

    realtime half_in  = 5.0;
    realtime half_out = 5.0;

    int checks = 0;
    int errors = 0;

    cdc_word_handshake #(.pWIDTH(W), .pSYNC(2), .pCNT(8)) dut (
        .clkin(clkin), .resetin(resetin), .clkout(clkout), .resetout(resetout),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
        .sin_done(sin_done), .drop_cnt(drop_cnt), .sout_valid(sout_valid),
        .sout_data(sout_data)
    );

    cdc_word_handshake #(.pWIDTH(W), .pSYNC(2), .pCNT(4)) dut4 (
        .clkin(clkin), .resetin(resetin), .clkout(clkout), .resetout(resetout),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready4),
        .sin_done(sin_done4), .drop_cnt(drop_cnt4), .sout_valid(sout_valid4),
        .sout_data(sout_data4)
    );

    initial begin
        #(half_in);
        forever begin
            clkin = ~clkin;
            #(half_in);
        end
    end

    initial begin
        #3.0;
        forever begin
            #(half_out);
            clkout = ~clkout;
        end
    end

    // Observed traffic, collected for the main sequence to judge
    logic [W-1:0] acc_q[$];
    logic [W-1:0] dlv_q[$];
    logic [W-1:0] last_out = '0;
    int drops_obs = 0;
    int done_n = 0;
    int acc4_n = 0;
    int done4_n = 0;
    int dlv4_n = 0;
    int hold_bad = 0;

    always @(negedge clkin) begin
        if (resetin) begin
            drops_obs <= 0;
        end else begin
            if (sin_valid && sin_ready) acc_q.push_back(sin_data);
            if (sin_valid && !sin_ready) drops_obs <= drops_obs + 1;
            if (sin_done) done_n <= done_n + 1;
            if (sin_valid && sin_ready4) acc4_n <= acc4_n + 1;
            if (sin_done4) done4_n <= done4_n + 1;
        end
    end

    always @(negedge clkout) begin
        if (!resetout) begin
            if (sout_valid) dlv_q.push_back(sout_data);
            else if (sout_data !== last_out) hold_bad <= hold_bad + 1;
            if (sout_valid4) dlv4_n <= dlv4_n + 1;
        end
        last_out <= sout_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        #0.2;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int n = 0;
        while (done_n <= base && n < budget) begin
            @(negedge clkin);
            n++;
        end
        chk(tag, 32'(done_n > base), 1);
    endtask

    task automatic send_word(input logic [W-1:0] word, input string tag);
        int d0 = dlv_q.size();
        int n0 = done_n;
        chk({tag, "_ready"}, 32'(sin_ready), 1);
        sin_valid = 1'b1;
        sin_data  = word;
        cyc();
        sin_valid = 1'b0;
        wait_done(n0, 300, {tag, "_done_seen"});
        repeat (10) cyc();
        chk({tag, "_deliveries"}, dlv_q.size() - d0, 1);
        if (dlv_q.size() > d0) chk({tag, "_data"}, 32'(dlv_q[d0]), 32'(word));
        chk({tag, "_dones"}, done_n - n0, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, a0;
        int timeouts;
        int lim;
        int exp_drop;
        bit accepted;
        int guard;
        int k;
        real frac, slow;

        resetin   = 1'b1;
        resetout  = 1'b1;
        sin_valid = 1'b0;
        sin_data  = '0;
        timeouts  = 0;
        #22;
        chk("rst_ready", 32'(sin_ready), 1);
        chk("rst_done", 32'(sin_done), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_sout_valid", 32'(sout_valid), 0);
        chk("rst_sout_data", 32'(sout_data), 0);
        cyc();
        resetin  = 1'b0;
        resetout = 1'b0;
        repeat (3) cyc();

        // Single word at equal clocks
        send_word(16'hA5A5, "t1");
        chk("t1_drop", 32'(drop_cnt), 0);

        // Source reset while the request has not yet reached clkout
        d0 = dlv_q.size();
        n0 = done_n;
        sin_valid = 1'b1;
        sin_data  = 16'h0BAD;
        cyc();
        resetin   = 1'b1;
        sin_valid = 1'b0;
        #1;
        chk("t4_ready_in_reset", 32'(sin_ready), 1);
        repeat (3) cyc();
        resetin = 1'b0;
        repeat (40) cyc();
        chk("t4_no_delivery", dlv_q.size() - d0, 0);
        chk("t4_no_done", done_n - n0, 0);
        chk("t4_ready_back", 32'(sin_ready), 1);
        chk("t4_drop_cleared", 32'(drop_cnt), 0);
        send_word(16'h5A5A, "t4_next");

        // Destination reset while req is high: word still arrives exactly once
        d0 = dlv_q.size();
        n0 = done_n;
        sin_valid = 1'b1;
        sin_data  = 16'hC3C3;
        cyc();
        resetout  = 1'b1;
        sin_valid = 1'b0;
        repeat (4) cyc();
        resetout = 1'b0;
        wait_done(n0, 300, "t5_done_seen");
        repeat (10) cyc();
        chk("t5_deliveries", dlv_q.size() - d0, 1);
        if (dlv_q.size() > d0) chk("t5_data", 32'(dlv_q[d0]), 32'h0000C3C3);
        chk("t5_dones", done_n - n0, 1);

        // Fast source, slow sink: held valid gives one transfer plus counted drops
        half_in  = 2.5;
        half_out = 15.15;
        repeat (6) cyc();
        d0 = dlv_q.size();
        n0 = done_n;
        sin_valid = 1'b1;
        sin_data  = 16'h1234;
        for (int i = 0; i < 25; i++) begin
            cyc();
            sin_data = 16'($urandom);
            if (i == 10) chk("t2_busy_ready", 32'(sin_ready), 0);
        end
        sin_valid = 1'b0;
        repeat (2) cyc();
        chk("t2_drop", 32'(drop_cnt), 24);
        chk("t2_drop_sat", 32'(drop_cnt4), 15);
        wait_done(n0, 400, "t2_done_seen");
        repeat (10) cyc();
        chk("t2_deliveries", dlv_q.size() - d0, 1);
        if (dlv_q.size() > d0) chk("t2_data", 32'(dlv_q[d0]), 32'h00001234);
        chk("t2_dones", done_n - n0, 1);
        chk("t2_drop_hold", 32'(drop_cnt4), 15);

        // 1000 random words over random clock ratios up to 7:1 either way
        a0 = acc_q.size();
        d0 = dlv_q.size();
        n0 = done_n;
        for (int c = 0; c < 10; c++) begin
            k    = $urandom_range(1, 6);
            frac = $urandom_range(0, 99) / 100.0;
            slow = 2.0 * (real'(k) + frac);
            if ($urandom_range(0, 1) == 1) begin
                half_in  = 2.0;
                half_out = slow;
            end else begin
                half_in  = slow;
                half_out = 2.0;
            end
            repeat (4) cyc();
            for (int w = 0; w < 100; w++) begin
                repeat ($urandom_range(0, 2)) cyc();
                sin_valid = 1'b1;
                sin_data  = 16'($urandom);
                accepted  = 1'b0;
                guard     = 0;
                while (!accepted && guard < 5000) begin
                    @(negedge clkin);
                    if (sin_ready) accepted = 1'b1;
                    cyc();
                    if (!accepted) sin_data = 16'($urandom);
                    guard++;
                end
                sin_valid = 1'b0;
                if (!accepted) timeouts++;
            end
            guard = 0;
            while ((done_n - n0) < (acc_q.size() - a0) && guard < 5000) begin
                @(negedge clkin);
                guard++;
            end
            repeat (20) cyc();
        end
        chk("rand_timeouts", timeouts, 0);
        chk("rand_accepts", acc_q.size() - a0, 1000);
        chk("rand_deliveries", dlv_q.size() - d0, acc_q.size() - a0);
        chk("rand_dones", done_n - n0, dlv_q.size() - d0);
        lim = acc_q.size() - a0;
        if ((dlv_q.size() - d0) < lim) lim = dlv_q.size() - d0;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("rand_word%0d", i), 32'(dlv_q[d0 + i]), 32'(acc_q[a0 + i]));
        end

        exp_drop = (drops_obs > 255) ? 255 : drops_obs;
        chk("drop_model", 32'(drop_cnt), exp_drop);
        exp_drop = (drops_obs > 15) ? 15 : drops_obs;
        chk("drop_model_sat", 32'(drop_cnt4), exp_drop);
        chk("sout_data_hold", hold_bad, 0);
        chk("twin_accepts", acc4_n, acc_q.size());
        chk("twin_deliveries", dlv4_n, dlv_q.size());
        chk("twin_dones", done4_n, done_n);
        chk("twin_data", 32'(sout_data4), 32'(sout_data));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
